// File: rtl/instruction_controller.sv
// rtl/instruction_controller.sv - instruction register and Moore sequencer driving datapath
module instruction_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        s,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] datapath_in
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WRITE_IMM,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WRITE_REG
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn, rd, rm;
    logic [1:0] sh;
    logic       is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign sh     = ir_q[4:3];
    assign rm     = ir_q[2:0];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);

    assign datapath_in = {{8{ir_q[7]}}, ir_q[7:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        w        = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        vsel     = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;

        case (state_q)
            S_WAIT: begin
                w = 1'b1;
                // IR captured on the same edge that starts; DECODE sees the new word
                if (load) ir_d = in;
                if (s) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_mov_imm)      state_d = S_WRITE_IMM;
                else if (is_mov_reg) state_d = S_GET_B;
                else if (is_alu)     state_d = S_GET_A;
                else                 state_d = S_WAIT;
            end
            S_WRITE_IMM: begin
                readnum  = rn;
                writenum = rn;
                vsel     = 1'b1;
                write    = 1'b1;
                state_d  = S_WAIT;
            end
            S_GET_A: begin
                readnum  = rn;
                writenum = rn;
                loada    = 1'b1;
                state_d  = S_GET_B;
            end
            S_GET_B: begin
                readnum  = rm;
                writenum = rm;
                loadb    = 1'b1;
                state_d  = S_ALU;
            end
            S_ALU: begin
                shift = sh;
                asel  = is_mov_reg || is_mvn;
                ALUop = is_alu ? op : 2'b00;
                if (is_cmp) begin
                    loads   = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    loadc   = 1'b1;
                    state_d = S_WRITE_REG;
                end
            end
            S_WRITE_REG: begin
                readnum  = rd;
                writenum = rd;
                write    = 1'b1;
                state_d  = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

endmodule

// File: tb/tb_instruction_controller.sv
// tb/tb_instruction_controller.sv - directed bench for instruction_controller
module tb_instruction_controller;

    logic        clk = 1'b0;
    logic        reset, load, s;
    logic [15:0] in;
    logic        w, write, vsel, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  shift, ALUop;
    logic [15:0] datapath_in;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int wr_base;

    instruction_controller dut (
        .clk(clk), .reset(reset), .load(load), .s(s), .in(in),
        .w(w), .readnum(readnum), .writenum(writenum), .write(write),
        .vsel(vsel), .loada(loada), .loadb(loadb), .loadc(loadc),
        .loads(loads), .asel(asel), .bsel(bsel), .shift(shift),
        .ALUop(ALUop), .datapath_in(datapath_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (write === 1'b1) wr_cnt <= wr_cnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [15:0] instr);
        load = 1'b1; s = 1'b1; in = instr;
        wr_base = wr_cnt;
        tick();
        load = 1'b0; s = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; s = 1'b0; in = 16'h0000;
        tick();
        reset = 1'b0;
        chk("rst_w", {15'd0, w}, 16'd1);
        chk("rst_write", {15'd0, write}, 16'd0);
        chk("rst_dpin", datapath_in, 16'h0000);
        chk("rst_ctrl", {readnum, writenum, vsel, loada, loadb, loadc, loads, asel, bsel, shift, ALUop},
            16'h0000);

        // MOV R1,#7
        start(16'hD107);
        chk("movi1_dec_w", {15'd0, w}, 16'd0);
        chk("movi1_dec_write", {15'd0, write}, 16'd0);
        tick();
        chk("movi1_w", {15'd0, w}, 16'd0);
        chk("movi1_wnum", {13'd0, writenum}, 16'd1);
        chk("movi1_vsel_write", {14'd0, vsel, write}, 16'b11);
        chk("movi1_dpin", datapath_in, 16'h0007);
        tick();
        chk("movi1_done_w", {15'd0, w}, 16'd1);
        chk("movi1_pulses", 16'(wr_cnt - wr_base), 16'd1);

        // MOV R2,#-3
        start(16'hD2FD);
        tick();
        chk("movi2_wnum", {13'd0, writenum}, 16'd2);
        chk("movi2_dpin", datapath_in, 16'hFFFD);
        tick();
        chk("movi2_done_w", {15'd0, w}, 16'd1);

        // ADD R3,R1,R2 LSL1
        start(16'hA16A);
        chk("add_dec_loada", {15'd0, loada}, 16'd0);
        tick();
        chk("add_geta", {13'd0, readnum, loada, loadb}, {13'd1, 2'b10});
        tick();
        chk("add_getb", {13'd0, readnum, loada, loadb}, {13'd2, 2'b01});
        tick();
        chk("add_alu", {9'd0, shift, ALUop, asel, bsel, loadc, loads}, {9'd0, 2'b01, 2'b00, 4'b0010});
        chk("add_alu_write", {15'd0, write}, 16'd0);
        tick();
        chk("add_wb", {11'd0, writenum, vsel, write}, {11'd0, 3'd3, 2'b01});
        chk("add_wb_w", {15'd0, w}, 16'd0);
        tick();
        chk("add_done_w", {15'd0, w}, 16'd1);
        chk("add_pulses", 16'(wr_cnt - wr_base), 16'd1);

        // CMP R1,R2
        start(16'hA902);
        tick(); tick(); tick();
        chk("cmp_alu", {10'd0, ALUop, loadc, loads, write, w}, {10'd0, 2'b01, 4'b0100});
        tick();
        chk("cmp_done_w", {15'd0, w}, 16'd1);
        chk("cmp_pulses", 16'(wr_cnt - wr_base), 16'd0);

        // MOV R4,R1 LSR
        start(16'hC091);
        tick();
        chk("movr_getb", {13'd0, readnum, loada, loadb}, {13'd1, 2'b01});
        tick();
        chk("movr_alu", {9'd0, shift, ALUop, asel, bsel, loadc, loads}, {9'd0, 2'b10, 2'b00, 4'b1010});
        tick();
        chk("movr_wb", {11'd0, writenum, vsel, write}, {11'd0, 3'd4, 2'b01});
        tick();
        chk("movr_done_w", {15'd0, w}, 16'd1);

        // illegal, with a load attempt while busy
        start(16'h0000);
        chk("ill_dec", {12'd0, w, loada, loadb, write}, 16'd0);
        load = 1'b1; in = 16'hD107;
        tick();
        load = 1'b0;
        chk("ill_done_w", {15'd0, w}, 16'd1);
        chk("ill_ir_kept", datapath_in, 16'h0000);
        chk("ill_pulses", 16'(wr_cnt - wr_base), 16'd0);

        // MVN R7,R1 with s held so the next instruction starts from WAIT immediately
        load = 1'b1; s = 1'b1; in = 16'hB8E1;
        tick();
        load = 1'b0;
        tick(); tick(); tick();
        chk("mvn_alu", {9'd0, ALUop, asel, loadc, write}, {9'd0, 2'b11, 3'b110});
        tick();
        chk("mvn_wb", {12'd0, writenum, write}, {12'd0, 3'd7, 1'b1});
        tick();
        chk("mvn_done_w", {15'd0, w}, 16'd1);
        tick();
        chk("b2b_restart_w", {15'd0, w}, 16'd0);
        s = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // ADD interrupted by reset in GET_B; reset beats load/s
        start(16'hA16A);
        tick(); tick();
        chk("rst_mid_getb", {15'd0, loadb}, 16'd1);
        reset = 1'b1; load = 1'b1; s = 1'b1; in = 16'hD107;
        tick();
        reset = 1'b0; load = 1'b0; s = 1'b0;
        chk("rst_mid_w", {15'd0, w}, 16'd1);
        chk("rst_mid_ctrl", {readnum, writenum, vsel, loada, loadb, loadc, loads, asel, bsel, shift, ALUop},
            16'h0000);
        chk("rst_mid_write", {15'd0, write}, 16'd0);
        chk("rst_mid_ir", datapath_in, 16'h0000);
        tick();
        chk("rst_mid_pulses", 16'(wr_cnt - wr_base), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_controller.md
# instruction_controller

Instruction register plus Moore state machine that sits directly upstream of `datapath` and replaces the switch-driven control inputs on the board top. It latches a 16-bit instruction, decodes it, and sequences `datapath` through register-read, compute and write-back stages, one control step per clock. It supports MOV-immediate, MOV-register, ADD, CMP, AND and MVN.

## Interface
Parameters: none (widths are fixed by `datapath`).

- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; forces WAIT and clears IR
- load  in  1  IR load enable; honoured only while `w`=1
- s  in  1  start; honoured only while `w`=1
- in  in  16  instruction word captured into IR
- w  out  1  idle/wait flag; 1 only in WAIT
- readnum  out  3  register read select to `datapath`
- writenum  out  3  register write select to `datapath`
- write  out  1  register-file write enable
- vsel  out  1  write-data select: 1 = `datapath_in`, 0 = C register
- loada, loadb, loadc, loads  out  1 each  `datapath` load enables
- asel, bsel  out  1 each  ALU operand selects; asel=1 forces A=0
- shift  out  2  shifter control
- ALUop  out  2  ALU operation
- datapath_in  out  16  sign-extended IR[7:0]

## Operation
- IR fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0], imm8=IR[7:0].
- Decode table:
  - 110/10 is MOV Rn,#imm8.
  - 110/00 is MOV Rd,Rm{sh}.
  - 101/op is the ALU group: op 00 ADD, 01 CMP, 10 AND, 11 MVN.
  - Any other encoding is illegal.
- datapath_in = {{8{IR[7]}},IR[7:0]}, driven continuously.
- All outputs are Moore functions of (state, IR). Any control not listed for a state is 0.
- States and transitions:
  - WAIT: w=1. On load=1, IR<=in. If s=1, go to DECODE. When load and s are both 1, IR loads and DECODE uses the new IR.
  - DECODE: outputs idle. MOV-imm goes to WRITE_IMM. MOV-reg goes to GET_B. ALU group goes to GET_A. Illegal goes to WAIT, with no write and no load.
  - WRITE_IMM: writenum=Rn, vsel=1, write=1. Next state WAIT.
  - GET_A: readnum=Rn, loada=1. Next state GET_B.
  - GET_B: readnum=Rm, loadb=1. Next state ALU.
  - ALU: shift=sh, bsel=0.
    - asel=1 for MOV-reg and MVN, 0 otherwise.
    - ALUop=op for the ALU group; ALUop=00 for MOV-reg.
    - CMP: loads=1, loadc=0, next state WAIT.
    - All others: loadc=1, loads=0, next state WRITE_REG.
  - WRITE_REG: writenum=Rd, vsel=0, write=1. Next state WAIT.
- In non-write states, writenum=readnum=the selected field, or 0 when idle.
- `load` and `s` outside WAIT are ignored. IR is never modified mid-instruction.

## Timing
- Reset values: state=WAIT, IR=0, w=1, every other output 0. datapath_in=0 because IR=0.
- Reset has priority over load and s. Reset asserted in any state means WAIT after that edge, and no write in the following cycle. Any partially loaded A/B/C contents are abandoned.
- Latency counts edges from the edge that samples s=1 to the edge that returns to WAIT (w=1):
  - MOV-imm: 3. Register is written on edge 3.
  - MOV-reg: 5.
  - ADD/AND/MVN: 6. Register is written on edge 6.
  - CMP: 5. Status is loaded on edge 5.
  - Illegal: 2.
- Exactly one write pulse per writing instruction, one cycle wide. CMP and illegal instructions produce none.
- Back-to-back: s held high in WAIT starts the next instruction on that same edge. There are no bubble cycles beyond WAIT itself.

## Test plan
- Reset, load 16'hD107, pulse s -> w=0 for 2 cycles. WRITE_IMM shows writenum=1, vsel=1, write=1, datapath_in=16'h0007. w=1 after the third edge.
- Load 16'hD2FD (MOV R2,#-3) -> datapath_in=16'hFFFD during WRITE_IMM. With `datapath` attached, R2=16'hFFFD.
- Load 16'hA16A (ADD R3,R1,R2 LSL1) after the two MOVs -> outputs in order:
  - readnum=1/loada;
  - readnum=2/loadb;
  - shift=01, ALUop=00, asel=0, loadc=1;
  - writenum=3, vsel=0, write=1.
  - w returns after 6 edges; R3=16'h0001.
- Load 16'hA902 (CMP R1,R2) -> ALU state has loads=1 and loadc=0. No write pulse. w returns after 5 edges. Load 16'hC091 (MOV R4,R1 LSR) -> GET_A is skipped, asel=1, shift=10, writenum=4.
- Illegal 16'h0000 -> DECODE then WAIT. No load or write is asserted; w=1 after 2 edges. Pulsing load with 16'hD107 while busy leaves IR unchanged.
- Start ADD, assert reset during GET_B -> w=1 and all controls 0 on the next cycle. No write occurs. IR=0.
